// File: rtl/multi_port_register_file_if.sv
// Bus interface for multi_port_register_file: read/write/clear requests in,
// registered read data and status out.
interface multi_port_register_file_if #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int MEM_WORD_SIZE    = 64
);
  logic [REG_ADDRESS_SIZE-1:0] selA;
  logic [REG_ADDRESS_SIZE-1:0] selB;
  logic                        readEn;
  logic [REG_ADDRESS_SIZE-1:0] selWrite;
  logic [MEM_WORD_SIZE-1:0]    writeIn;
  logic                        writeEn;
  logic                        clearStart;
  logic [MEM_WORD_SIZE-1:0]    outA;
  logic [MEM_WORD_SIZE-1:0]    outB;
  logic                        outValid;
  logic                        busy;

  modport master (
    output selA, selB, readEn, selWrite, writeIn, writeEn, clearStart,
    input  outA, outB, outValid, busy
  );

  modport slave (
    input  selA, selB, readEn, selWrite, writeIn, writeEn, clearStart,
    output outA, outB, outValid, busy
  );
endinterface

// File: rtl/multi_port_register_file.sv
// Register file with two registered read ports, one write port, write-to-read
// bypass, async active-high reset and a one-entry-per-cycle clear engine.
// Optional build macro REGFILE_ZERO_REG_EN: register 0 reads as zero, writes
// to it are discarded and reads of it are never bypassed.
//
// state | meaning
// IDLE  | normal read/write operation, clearStart accepted
// CLEAR | zeroing regs[clearPtr] each cycle; ports ignored, busy = 1
module multi_port_register_file #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int NUM_REG          = 2**REG_ADDRESS_SIZE,
  parameter int MEM_WORD_SIZE    = 64
) (
  input logic                       clk,
  input logic                       reset,
  multi_port_register_file_if.slave bus
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [REG_ADDRESS_SIZE-1:0] LAST_PTR = REG_ADDRESS_SIZE'(NUM_REG - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                      state, stateNext;
  logic [REG_ADDRESS_SIZE-1:0] clearPtr, clearPtrNext;
  logic [MEM_WORD_SIZE-1:0]    regs [NUM_REG];
  logic                        doWrite, doRead;
  logic [MEM_WORD_SIZE-1:0]    readA, readB;
  logic [MEM_WORD_SIZE-1:0]    outARegs, outBRegs;
  logic                        outValidReg;

  // State and clear pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clearPtr <= '0;
    end else begin
      state    <= stateNext;
      clearPtr <= clearPtrNext;
    end
  end

  // Next-state logic and port qualification; ports are only honoured in IDLE.
  always_comb begin
    stateNext    = state;
    clearPtrNext = clearPtr;
    doWrite      = 1'b0;
    doRead       = 1'b0;
    case (state)
      IDLE: begin
        doWrite = bus.writeEn && !(ZERO_REG && (bus.selWrite == '0));
        doRead  = bus.readEn;
        if (bus.clearStart) begin
          stateNext    = CLEAR;
          clearPtrNext = '0;
        end
      end
      CLEAR: begin
        clearPtrNext = clearPtr + 1'b1;
        if (clearPtr == LAST_PTR) begin
          stateNext    = IDLE;
          clearPtrNext = '0;
        end
      end
      default: begin
        stateNext    = IDLE;
        clearPtrNext = '0;
      end
    endcase
  end

  // Read muxes with same-cycle write bypass; a hardwired zero register wins.
  always_comb begin
    readA = regs[bus.selA];
    readB = regs[bus.selB];
    if (doWrite && (bus.selWrite == bus.selA)) readA = bus.writeIn;
    if (doWrite && (bus.selWrite == bus.selB)) readB = bus.writeIn;
    if (ZERO_REG && (bus.selA == '0)) readA = '0;
    if (ZERO_REG && (bus.selB == '0)) readB = '0;
  end

  // Storage array: the clear engine takes priority, otherwise the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REG; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[clearPtr] <= '0;
    end else if (doWrite) begin
      regs[bus.selWrite] <= bus.writeIn;
    end
  end

  // Registered read outputs; data holds when no read is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outARegs    <= '0;
      outBRegs    <= '0;
      outValidReg <= 1'b0;
    end else if (doRead) begin
      outARegs    <= readA;
      outBRegs    <= readB;
      outValidReg <= 1'b1;
    end else begin
      outValidReg <= 1'b0;
    end
  end

  assign bus.outA     = outARegs;
  assign bus.outB     = outBRegs;
  assign bus.outValid = outValidReg;
  assign bus.busy     = (state == CLEAR);

endmodule

// File: tb/tb_multi_port_register_file.sv
// Bench for multi_port_register_file: a cycle-level reference model checked
// against the DUT on every falling edge, plus hand-computed literal checks.
module tb_multi_port_register_file;
  localparam int AW  = 5;
  localparam int NUM = 32;
  localparam int W   = 64;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  multi_port_register_file_if #(.REG_ADDRESS_SIZE(AW), .MEM_WORD_SIZE(W)) bus ();

  multi_port_register_file #(.REG_ADDRESS_SIZE(AW), .NUM_REG(NUM), .MEM_WORD_SIZE(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] mem [NUM];
  logic [W-1:0] mA = '0, mB = '0;
  logic         mV = 1'b0;
  int           clearLeft = 0;

  initial for (int i = 0; i < NUM; i++) mem[i] = '0;

  function automatic logic [W-1:0] mRead(input logic [AW-1:0] a);
    if (ZR && a == 0) return '0;
    if (bus.writeEn && bus.selWrite == a && !(ZR && bus.selWrite == 0)) return bus.writeIn;
    return mem[a];
  endfunction

  // Model: a clear request costs NUM busy cycles, wiping entry NUM-clearLeft each cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) mem[i] = '0;
      mA = '0; mB = '0; mV = 1'b0; clearLeft = 0;
    end else if (clearLeft > 0) begin
      mem[NUM - clearLeft] = '0;
      clearLeft = clearLeft - 1;
      mV = 1'b0;
    end else begin
      if (bus.readEn) begin
        mA = mRead(bus.selA);
        mB = mRead(bus.selB);
        mV = 1'b1;
      end else begin
        mV = 1'b0;
      end
      if (bus.writeEn && !(ZR && bus.selWrite == 0)) mem[bus.selWrite] = bus.writeIn;
      if (bus.clearStart) clearLeft = NUM;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model every falling edge.
  always @(negedge clk) begin
    check("outA",     bus.outA, mA);
    check("outB",     bus.outB, mB);
    check("outValid", W'(bus.outValid), W'(mV));
    check("busy",     W'(bus.busy), W'(clearLeft > 0));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.readEn = 1'b0; bus.writeEn = 1'b0; bus.clearStart = 1'b0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    tick(); idle();
    bus.writeEn = 1'b1; bus.selWrite = AW'(a); bus.writeIn = d;
  endtask

  task automatic rd(input int a, input int b);
    tick(); idle();
    bus.readEn = 1'b1; bus.selA = AW'(a); bus.selB = AW'(b);
  endtask

  task automatic asyncReset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_outA",  bus.outA, '0);
    check("rst_outB",  bus.outB, '0);
    check("rst_valid", W'(bus.outValid), '0);
    check("rst_busy",  W'(bus.busy), '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busyCnt;
    bit done;
    idle();
    bus.selA = '0; bus.selB = '0; bus.selWrite = '0; bus.writeIn = '0;
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // 1: reset mid-operation, then r7 reads 0
    wr(7, 64'h77);
    rd(7, 7);
    asyncReset();
    tick(); reset = 1'b0; idle();
    rd(7, 7);
    tick(); idle();
    check("t1_r7", bus.outA, 64'h0);

    // 2: write then read on the next cycle
    wr(5, 64'hDEAD_BEEF);
    rd(5, 7);
    tick(); idle();
    check("t2_outA",  bus.outA, 64'hDEAD_BEEF);
    check("t2_valid", W'(bus.outValid), 64'h1);

    // 3: same-cycle write and read of the same address bypasses both ports
    tick(); idle();
    bus.writeEn = 1'b1; bus.selWrite = 3; bus.writeIn = 64'h1234;
    bus.readEn = 1'b1; bus.selA = 3; bus.selB = 3;
    tick(); idle();
    check("t3_outA", bus.outA, 64'h1234);
    check("t3_outB", bus.outB, 64'h1234);
    rd(3, 5);
    tick(); idle();
    check("t3_hold_outB", bus.outB, 64'hDEAD_BEEF);

    // 4: fill, clear, traffic dropped while busy, all zero afterwards
    for (int i = 0; i < NUM; i++) wr(i, W'(i + 1));
    rd(31, 1);
    tick(); idle();
    check("t4_r31_pre", bus.outA, 64'd32);
    bus.clearStart = 1'b1;
    tick(); idle();
    busyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) begin
        busyCnt++;
        bus.writeEn = 1'b1; bus.readEn = 1'b1;
        bus.selWrite = AW'($urandom_range(NUM - 1));
        bus.selA = AW'($urandom_range(NUM - 1));
        bus.writeIn = {$urandom, $urandom};
        bus.clearStart = 1'($urandom_range(1));
      end else begin
        idle();
      end
      tick();
    end
    idle();
    check("t4_busy_cycles", W'(busyCnt), 64'd32);
    for (int i = 0; i < NUM; i++) rd(i, NUM - 1 - i);
    tick(); idle();
    check("t4_last_read", bus.outA, 64'h0);

    // 5: reset at clear cycle 10, then a fresh clear is accepted
    wr(9, 64'h99);
    tick(); idle(); bus.clearStart = 1'b1;
    tick(); idle();
    for (int i = 0; i < 9; i++) tick();
    check("t5_busy_before", W'(bus.busy), 64'h1);
    asyncReset();
    tick(); reset = 1'b0; idle();
    bus.clearStart = 1'b1;
    tick(); idle();
    check("t5_busy_restart", W'(bus.busy), 64'h1);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (!bus.busy) done = 1'b1;
    end
    check("t5_clear_done", W'(done), 64'h1);

    // 6: register 0 behaviour
    wr(0, 64'hFF);
    rd(0, 0);
    tick(); idle();
    check("t6_r0", bus.outA, ZR ? 64'h0 : 64'hFF);
    bus.writeEn = 1'b1; bus.selWrite = 0; bus.writeIn = 64'hAB;
    bus.readEn = 1'b1; bus.selA = 0; bus.selB = 0;
    tick(); idle();
    check("t6_r0_bypass", bus.outB, ZR ? 64'h0 : 64'hAB);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
